// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch opcodes and REGIMM rt selectors.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASSA = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/ex_alu_core.sv
// Pure combinational 32-bit ALU with Z/N flags; zero latency, no backpressure.
// ALU_OVERFLOW_FLAG_EN adds the signed-overflow flag v for add/sub.
module ex_alu_core
  import ex_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic            v,
`endif
  output logic [XLEN-1:0] y,
  output logic            z,
  output logic            n
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_NOR:   y = ~(a | b);
      ALU_SLL:   y = b << a[4:0];
      ALU_SRL:   y = b >> a[4:0];
      ALU_SRA:   y = $signed(b) >>> a[4:0];
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_PASSA: y = a;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

  assign z = (y == '0);
  assign n = y[XLEN-1];

`ifdef ALU_OVERFLOW_FLAG_EN
  // Overflow shows up as the result sign disagreeing with a when the effective operands share a sign.
  always_comb begin
    v = 1'b0;
    if (op == ALU_ADD)
      v = (a[XLEN-1] == b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]);
    else if (op == ALU_SUB)
      v = (a[XLEN-1] != b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]);
  end
`endif

endmodule

// File: rtl/ex_alu_branch_unit.sv
// Execute stage: ALU, PC incrementer, branch condition (zero latency) plus EX/MEM copy registered on le.
// No backpressure; le simply holds the registers. ALU_OVERFLOW_FLAG_EN adds v/v_q.
module ex_alu_branch_unit
  import ex_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] PC_INC = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              b_instr,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] pc_in,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic              v,
  output logic              v_q,
`endif
  output logic [DATA_W-1:0] alu_out,
  output logic              z,
  output logic              n,
  output logic              taken,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] alu_out_q,
  output logic              taken_q,
  output logic [1:0]        zn_q
);

  ex_alu_core u_alu (
    .op (op),
    .a  (a),
    .b  (b),
`ifdef ALU_OVERFLOW_FLAG_EN
    .v  (v),
`endif
    .y  (alu_out),
    .z  (z),
    .n  (n)
  );

  assign pc_plus4 = pc_in + PC_INC;

  // Anything that is not a conditional branch is treated as an unconditional transfer.
  always_comb begin
    taken = 1'b0;
    if (b_instr) begin
      case (opcode)
        OP_BEQ:  taken = z;
        OP_BNE:  taken = ~z;
        OP_BLEZ: taken = n | z;
        OP_BGTZ: taken = ~n & ~z;
        OP_REGIMM: begin
          case (rt)
            RT_BLTZ, RT_BLTZAL: taken = n;
            RT_BGEZ, RT_BGEZAL: taken = ~n;
            default:            taken = 1'b0;
          endcase
        end
        default: taken = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_q <= '0;
      taken_q   <= 1'b0;
      zn_q      <= 2'b00;
`ifdef ALU_OVERFLOW_FLAG_EN
      v_q       <= 1'b0;
`endif
    end else if (le) begin
      alu_out_q <= alu_out;
      taken_q   <= taken;
      zn_q      <= {z, n};
`ifdef ALU_OVERFLOW_FLAG_EN
      v_q       <= v;
`endif
    end
  end

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Randomized and directed checks of ex_alu_branch_unit against a behavioural model.
module tb_ex_alu_branch_unit;

  logic        clk = 1'b0;
  logic        reset, le, b_instr;
  logic [3:0]  op;
  logic [31:0] a, b, pc_in;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [31:0] alu_out, pc_plus4, alu_out_q;
  logic        z, n, taken, taken_q;
  logic [1:0]  zn_q;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        v, v_q;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ex_alu_branch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .le        (le),
    .op        (op),
    .a         (a),
    .b         (b),
    .b_instr   (b_instr),
    .opcode    (opcode),
    .rt        (rt),
    .pc_in     (pc_in),
`ifdef ALU_OVERFLOW_FLAG_EN
    .v         (v),
    .v_q       (v_q),
`endif
    .alu_out   (alu_out),
    .z         (z),
    .n         (n),
    .taken     (taken),
    .pc_plus4  (pc_plus4),
    .alu_out_q (alu_out_q),
    .taken_q   (taken_q),
    .zn_q      (zn_q)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_alu(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    longint unsigned ux, uy;
    logic [63:0] ext;
    int          sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    sh = int'(x % 32);
    case (f)
      4'd0:  m_alu = 32'((ux + uy) % 64'h1_0000_0000);
      4'd1:  m_alu = 32'((ux + 64'h1_0000_0000 - uy) % 64'h1_0000_0000);
      4'd2:  m_alu = x & y;
      4'd3:  m_alu = x | y;
      4'd4:  m_alu = x ^ y;
      4'd5:  m_alu = ~(x | y);
      4'd6:  m_alu = 32'((uy * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd7:  m_alu = 32'(uy / (64'd1 << sh));
      4'd8: begin
        ext = 64'(sy);
        ext = 64'($signed(ext) >>> sh);
        m_alu = ext[31:0];
      end
      4'd9:  m_alu = (sx < sy) ? 32'd1 : 32'd0;
      4'd10: m_alu = (ux < uy) ? 32'd1 : 32'd0;
      4'd11: m_alu = x;
      4'd12: m_alu = y;
      default: m_alu = 32'd0;
    endcase
  endfunction

  function automatic logic m_ovf(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    longint s;
    m_ovf = 1'b0;
    if (f == 4'd0 || f == 4'd1) begin
      s = (f == 4'd0) ? longint'($signed(x)) + longint'($signed(y))
                      : longint'($signed(x)) - longint'($signed(y));
      m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  function automatic logic m_taken(input logic bi, input logic [5:0] oc, input logic [4:0] r,
                                   input logic [31:0] res);
    logic zz, nn;
    zz = (res == 32'd0);
    nn = ($signed(res) < 0);
    if (!bi) return 1'b0;
    if (oc == 6'd4) return zz;
    if (oc == 6'd5) return !zz;
    if (oc == 6'd6) return nn || zz;
    if (oc == 6'd7) return !nn && !zz;
    if (oc == 6'd1) begin
      if (r == 5'd0 || r == 5'd16) return nn;
      if (r == 5'd1 || r == 5'd17) return !nn;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: rnd_operand = 32'd0;
      1: rnd_operand = 32'hFFFF_FFFF;
      2: rnd_operand = 32'h8000_0000;
      3: rnd_operand = 32'h7FFF_FFFF;
      default: rnd_operand = $urandom;
    endcase
  endfunction

  task automatic drive(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    op = f; a = x; b = y;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; le = 1'b1; b_instr = 1'b1; opcode = 6'd2; rt = 5'd0;
    op = 4'd11; a = 32'hDEAD_BEEF; b = 32'd0; pc_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({alu_out_q, taken_q, zn_q} !== 35'd0)
      $display("FAIL reset_regs got %h/%b/%b want 0/0/00", alu_out_q, taken_q, zn_q);
    else passed++;
`ifdef ALU_OVERFLOW_FLAG_EN
    total++;
    if (v_q !== 1'b0) $display("FAIL reset_v_q got %b want 0", v_q); else passed++;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_alu_directed();
    drive(4'd0, 32'hFFFF_FFFF, 32'd1);
    total++;
    if ({alu_out, z, n} !== {32'd0, 1'b1, 1'b0})
      $display("FAIL add_wrap got %h z%b n%b want 0 z1 n0", alu_out, z, n);
    else passed++;
    drive(4'd1, 32'd0, 32'd1);
    total++;
    if ({alu_out, n} !== {32'hFFFF_FFFF, 1'b1})
      $display("FAIL sub_wrap got %h n%b want ffffffff n1", alu_out, n);
    else passed++;
    drive(4'd8, 32'd4, 32'h8000_0000);
    total++;
    if (alu_out !== 32'hF800_0000) $display("FAIL sra got %h want f8000000", alu_out); else passed++;
    drive(4'd7, 32'd4, 32'h8000_0000);
    total++;
    if (alu_out !== 32'h0800_0000) $display("FAIL srl got %h want 08000000", alu_out); else passed++;
    drive(4'd9, 32'hFFFF_FFFF, 32'd1);
    total++;
    if (alu_out !== 32'd1) $display("FAIL slt got %h want 1", alu_out); else passed++;
    drive(4'd10, 32'hFFFF_FFFF, 32'd1);
    total++;
    if (alu_out !== 32'd0) $display("FAIL sltu got %h want 0", alu_out); else passed++;
`ifdef ALU_OVERFLOW_FLAG_EN
    drive(4'd0, 32'h7FFF_FFFF, 32'd1);
    total++;
    if ({v, alu_out, n} !== {1'b1, 32'h8000_0000, 1'b1})
      $display("FAIL add_ovf got v%b %h n%b want v1 80000000 n1", v, alu_out, n);
    else passed++;
`endif
  endtask

  task automatic test_alu_random();
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
      exp = m_alu(op, a, b);
      total++;
      if ({alu_out, z, n} !== {exp, exp == 32'd0, exp[31]})
        $display("FAIL alu_rand op%0d a=%h b=%h got %h z%b n%b want %h", op, a, b, alu_out, z, n, exp);
      else passed++;
`ifdef ALU_OVERFLOW_FLAG_EN
      total++;
      if (v !== m_ovf(op, a, b))
        $display("FAIL ovf_rand op%0d a=%h b=%h got %b want %b", op, a, b, v, m_ovf(op, a, b));
      else passed++;
`endif
    end
  endtask

  task automatic test_branch();
    logic [5:0] ocs [6];
    logic [4:0] rts [5];
    ocs = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd2};
    rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd5};
    b_instr = 1'b1; opcode = 6'b000111;
    drive(4'd11, 32'd5, 32'd0);
    total++;
    if (taken !== 1'b1) $display("FAIL bgtz_pos got %b want 1", taken); else passed++;
    drive(4'd11, 32'd0, 32'd0);
    total++;
    if (taken !== 1'b0) $display("FAIL bgtz_zero got %b want 0", taken); else passed++;
    opcode = 6'b000001; rt = 5'd0;
    drive(4'd11, 32'h8000_0000, 32'd0);
    total++;
    if (taken !== 1'b1) $display("FAIL bltz_neg got %b want 1", taken); else passed++;
    b_instr = 1'b0;
    for (int oc = 0; oc < 64; oc++) begin
      opcode = 6'(oc); rt = 5'($urandom);
      drive(4'd11, rnd_operand(), 32'd0);
      total++;
      if (taken !== 1'b0) $display("FAIL no_branch oc%0d got %b want 0", oc, taken); else passed++;
    end
    for (int i = 0; i < 300; i++) begin
      b_instr = ($urandom_range(0, 7) != 0);
      opcode  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ocs[$urandom_range(0, 5)];
      rt      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : rts[$urandom_range(0, 4)];
      a = rnd_operand();
      b = ($urandom_range(0, 2) == 0) ? a : rnd_operand();
      drive(($urandom_range(0, 1) != 0) ? 4'd1 : 4'd11, a, b);
      total++;
      if (taken !== m_taken(b_instr, opcode, rt, m_alu(op, a, b)))
        $display("FAIL taken_rand bi%b oc%b rt%b op%0d a=%h b=%h got %b", b_instr, opcode, rt, op, a, b, taken);
      else passed++;
    end
  endtask

  task automatic test_pc();
    logic [31:0] exp;
    pc_in = 32'h0000_0008; #1;
    total++;
    if (pc_plus4 !== 32'h0000_000C) $display("FAIL pc_8 got %h want 0000000c", pc_plus4); else passed++;
    pc_in = 32'hFFFF_FFFC; #1;
    total++;
    if (pc_plus4 !== 32'd0) $display("FAIL pc_wrap got %h want 0", pc_plus4); else passed++;
    for (int i = 0; i < 50; i++) begin
      pc_in = rnd_operand(); #1;
      exp = 32'(({32'd0, pc_in} + 64'd4) % 64'h1_0000_0000);
      total++;
      if (pc_plus4 !== exp) $display("FAIL pc_rand in=%h got %h want %h", pc_in, pc_plus4, exp); else passed++;
    end
  endtask

  task automatic test_regs();
    logic [31:0] e_out;
    logic        e_tk;
    logic [1:0]  e_zn;
    logic        e_v;
    @(negedge clk);
    b_instr = 1'b0; le = 1'b1;
    drive(4'd2, 32'h0000_F0F0, 32'h0000_FF00);
    @(posedge clk); #1;
    total++;
    if ({alu_out_q, taken_q, zn_q} !== {32'h0000_F000, 1'b0, 2'b00})
      $display("FAIL reg_load got %h/%b/%b want 0000f000/0/00", alu_out_q, taken_q, zn_q);
    else passed++;
    @(negedge clk);
    le = 1'b0;
    drive(4'd11, 32'h1234_5678, 32'd0);
    @(posedge clk); #1;
    total++;
    if (alu_out_q !== 32'h0000_F000) $display("FAIL reg_hold got %h want 0000f000", alu_out_q); else passed++;
    e_out = 32'h0000_F000; e_tk = 1'b0; e_zn = 2'b00; e_v = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      le = ($urandom_range(0, 2) != 0);
      b_instr = $urandom_range(0, 1); opcode = 6'($urandom_range(0, 8)); rt = 5'($urandom_range(0, 17));
      drive(4'($urandom_range(0, 13)), rnd_operand(), rnd_operand());
      if (le) begin
        e_out = m_alu(op, a, b);
        e_tk  = m_taken(b_instr, opcode, rt, e_out);
        e_zn  = {e_out == 32'd0, e_out[31]};
        e_v   = m_ovf(op, a, b);
      end
      @(posedge clk); #1;
      total++;
      if ({alu_out_q, taken_q, zn_q} !== {e_out, e_tk, e_zn})
        $display("FAIL reg_rand le%b got %h/%b/%b want %h/%b/%b", le, alu_out_q, taken_q, zn_q, e_out, e_tk, e_zn);
      else passed++;
`ifdef ALU_OVERFLOW_FLAG_EN
      total++;
      if (v_q !== e_v) $display("FAIL v_q_rand got %b want %b", v_q, e_v); else passed++;
`endif
    end
    // Asynchronous clear between edges, then make sure reset beats le at the next edge.
    @(negedge clk);
    le = 1'b1; b_instr = 1'b1; opcode = 6'd2;
    drive(4'd11, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0; #1;
    total++;
    if ({alu_out_q, taken_q, zn_q} !== 35'd0)
      $display("FAIL async_clear got %h/%b/%b want 0/0/00", alu_out_q, taken_q, zn_q);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (alu_out_q !== 32'd0) $display("FAIL reset_over_le got %h want 0", alu_out_q); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({alu_out_q, taken_q, zn_q} !== {32'hFFFF_FFFF, 1'b1, 2'b01})
      $display("FAIL reload got %h/%b/%b want ffffffff/1/01", alu_out_q, taken_q, zn_q);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_branch();
    test_pc();
    test_regs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
